priority_encoder_seq: RTL

//  Parametrised, registered successor to the 16-to-4 encoder. It captures a WIDTH-bit

---
 rtl/priority_encoder_seq_pkg.sv | 18 +
 rtl/priority_encoder_seq_prio_find.sv | 42 ++++
 rtl/priority_encoder_seq.sv | 95 +++++++++
 3 files changed

// File: rtl/priority_encoder_seq_pkg.sv
// Shared types and helpers for the sequential priority encoder: FSM state,
// mode encodings and the index-width rule used by every module in the slice.
package enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  localparam logic MODE_DRAIN  = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  // Index width for a vector of the given width; never narrower than one bit.
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/priority_encoder_seq_prio_find.sv
// Combinational priority finder: returns the index and one-hot mask of the
// priority bit of vec, plus whether any bit was set at all.
module prio_find
  import enc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic [WIDTH-1:0] onehot
);

  // Scan so that the winning bit is the last one assigned.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    onehot = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx       = IDX_W'(i);
          found     = 1'b1;
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx       = IDX_W'(i);
          found     = 1'b1;
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/priority_encoder_seq.sv
// Registered priority encoder: captures a request vector, then emits either its
// priority index (single mode) or every set index in priority order (drain mode).
module priority_encoder_seq
  import enc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inVector,
  input  logic             inMode,
  output logic             outValid,
  input  logic             outReady,
  output logic [IDX_W-1:0] outIndex,
  output logic             outLast,
  output logic             outNone,
  output enc_state_t       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never waits on ready, and an offered beat holds stable until it transfers.

  enc_state_t       state, state_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic             mode_q, mode_n;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic [WIDTH-1:0] onehot;
  logic             accept, retire, single_left;

  prio_find #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_find (
    .vec   (rem),
    .idx   (idx),
    .found (found),
    .onehot(onehot)
  );

  // Beat outputs derive only from registered state, so they hold under backpressure.
  assign single_left = ((rem & (rem - WIDTH'(1))) == '0);
  assign outValid    = (state == EMIT);
  assign outIndex    = outValid ? idx : '0;
  assign outNone     = outValid && !found;
  assign outLast     = outValid && ((mode_q == MODE_SINGLE) || single_left);
  assign retire      = outValid && outReady;
  assign inReady     = enable && rst_n && ((state == IDLE) || (retire && outLast));
  assign accept      = inValid && inReady;
  assign dbg_state   = state;

  always_comb begin
    state_n = state;
    rem_n   = rem;
    mode_n  = mode_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = EMIT;
          rem_n   = inVector;
          mode_n  = inMode;
        end
      end
      EMIT: begin
        if (retire) begin
          if (!outLast) begin
            rem_n = rem & ~onehot;
          end else if (accept) begin
            rem_n  = inVector;
            mode_n = inMode;
          end else begin
            state_n = IDLE;
            rem_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      mode_q <= MODE_DRAIN;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      mode_q <= mode_n;
    end
  end

endmodule
